// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct fields, instruction encoders and the
// boot program that lives at the bottom of instruction memory.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [4:0] R_ZERO = 5'd0;
    localparam logic [4:0] R_T0   = 5'd8;
    localparam logic [4:0] R_T1   = 5'd9;
    localparam logic [4:0] R_T2   = 5'd10;
    localparam logic [4:0] R_T3   = 5'd11;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    localparam int unsigned BOOT_LEN = 8;

    localparam logic [31:0] BOOT_0 = enc_i(OP_ADDI, R_ZERO, R_T0, 16'd5);
    localparam logic [31:0] BOOT_1 = enc_i(OP_ADDI, R_ZERO, R_T1, 16'd10);
    localparam logic [31:0] BOOT_2 = enc_r(R_T0, R_T1, R_T2, FN_ADD);
    localparam logic [31:0] BOOT_3 = enc_i(OP_SW, R_ZERO, R_T2, 16'd0);
    localparam logic [31:0] BOOT_4 = enc_i(OP_LW, R_ZERO, R_T3, 16'd0);
    localparam logic [31:0] BOOT_5 = enc_i(OP_BEQ, R_T3, R_T2, 16'd1);
    localparam logic [31:0] BOOT_6 = enc_r(R_T0, R_T1, R_T2, FN_SUB);
    // Word target 7 = byte 0x1C: the halt loop jumps to itself.
    localparam logic [31:0] BOOT_7 = enc_j(OP_J, 26'd7);

endpackage

// File: rtl/program_rom_table.sv
// Combinational byte-address -> instruction lookup; anything past the boot
// program or beyond DEPTH reads as NOP.
module program_rom_table
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]        addr,
    output logic [mips_pkg::DATA_W-1:0] data
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0] idx;
    logic             unused_byte_offset;

    // Byte lanes within a word are irrelevant to a word-wide fetch.
    assign idx                = addr[ADDR_W-1:2];
    assign unused_byte_offset = ^addr[1:0];

    always_comb begin
        data = NOP;
        if (idx < IDX_W'(DEPTH) && idx < IDX_W'(BOOT_LEN)) begin
            case (idx[2:0])
                3'd0:    data = BOOT_0;
                3'd1:    data = BOOT_1;
                3'd2:    data = BOOT_2;
                3'd3:    data = BOOT_3;
                3'd4:    data = BOOT_4;
                3'd5:    data = BOOT_5;
                3'd6:    data = BOOT_6;
                default: data = BOOT_7;
            endcase
        end
    end

endmodule

// File: rtl/program_memory.sv
// Fetch-stage instruction ROM: registered read of the word addressed by the
// PC, cleared to NOP by synchronous reset.
module program_memory
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA
);

    logic [mips_pkg::DATA_W-1:0] rom_data;

    program_rom_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .addr (ADDR),
        .data (rom_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DATA <= DATA_W'(NOP);
        end else begin
            DATA <= DATA_W'(rom_data);
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: directed fetch sequences with
// literal expectations plus a per-cycle comparison against a table model.
module tb_program_memory;

    logic        CLK;
    logic        RESET;
    logic [31:0] ADDR;
    logic [31:0] DATA;

    int unsigned n_pass;
    int unsigned n_total;

    program_memory #(
        .DEPTH  (64),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .DATA  (DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Boot program as listed by byte address; everything else is NOP.
    logic [31:0] prog [8];
    initial begin
        prog[0] = 32'h20080005;
        prog[1] = 32'h2009000A;
        prog[2] = 32'h01095020;
        prog[3] = 32'hAC0A0000;
        prog[4] = 32'h8C0B0000;
        prog[5] = 32'h116A0001;
        prog[6] = 32'h01095022;
        prog[7] = 32'h08000007;
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned w;
        w = int'(a / 4);
        if (w < 64 && w < 8) return prog[w];
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: DATA=%08h expected %08h", name, got, exp);
    endtask

    // Model-based comparison every cycle once a defined edge has occurred.
    logic [31:0] exp_q;
    logic        have_exp;
    initial have_exp = 1'b0;

    always @(posedge CLK) begin
        exp_q    = RESET ? 32'h0 : model_word(ADDR);
        have_exp = 1'b1;
    end

    always @(negedge CLK) begin
        if (have_exp) check("model", DATA, exp_q);
    end

    task automatic step(input logic rst, input logic [31:0] a,
                        input logic [31:0] exp, input string name);
        @(negedge CLK);
        RESET = rst;
        ADDR  = a;
        @(posedge CLK);
        #1;
        check(name, DATA, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] seq_exp [8];

    initial begin
        n_pass  = 0;
        n_total = 0;
        RESET   = 1'b1;
        ADDR    = 32'h04;

        seq_exp = '{32'h20080005, 32'h2009000A, 32'h01095020, 32'hAC0A0000,
                    32'h8C0B0000, 32'h116A0001, 32'h01095022, 32'h08000007};

        // Reset hold: address is ignored while RESET is high.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h04, 32'h00000000, "reset_hold");
        step(1'b0, 32'h04, 32'h2009000A, "reset_release");

        for (int i = 0; i < 8; i++) step(1'b0, 32'(i * 4), seq_exp[i], "seq_fetch");

        for (int i = 0; i < 5; i++) step(1'b0, 32'h08, 32'h01095020, "hold_0x08");
        repeat (3) @(posedge CLK);
        #1 check("hold_idle", DATA, 32'h01095020);

        step(1'b0, 32'h20,  32'h00000000, "nop_0x20");
        step(1'b0, 32'hFC,  32'h00000000, "nop_word63");
        step(1'b0, 32'h1C,  32'h08000007, "last_boot");
        step(1'b0, 32'h100, 32'h00000000, "oor_word64");
        step(1'b0, 32'hC8,  32'h00000000, "nop_0xC8");
        step(1'b0, 32'h00,  32'h20080005, "first_boot");
        step(1'b0, 32'h10000000, 32'h00000000, "oor_far");
        step(1'b0, 32'hFFFFFFFC, 32'h00000000, "oor_top");

        step(1'b0, 32'h09, 32'h01095020, "misalign_09");
        step(1'b0, 32'h0A, 32'h01095020, "misalign_0A");
        step(1'b0, 32'h0B, 32'h01095020, "misalign_0B");
        step(1'b0, 32'h1F, 32'h08000007, "misalign_1F");

        step(1'b0, 32'h10, 32'h8C0B0000, "mid_fetch");
        step(1'b1, 32'h10, 32'h00000000, "mid_reset");
        step(1'b0, 32'h14, 32'h116A0001, "mid_release");

        // Back-to-back address changes every cycle.
        step(1'b0, 32'h18, 32'h01095022, "b2b_18");
        step(1'b0, 32'h40, 32'h00000000, "b2b_40");
        step(1'b0, 32'h0C, 32'hAC0A0000, "b2b_0C");

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
